// File: rtl/bidir_pad_ctrl_if.sv
// Request/response bus for bidir_pad_ctrl.
// master: requester side; slave: controller side.
interface bidir_pad_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid,
    output req_write,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata
  );

endinterface

// File: rtl/bidir_pad_ctrl.sv
// Half-duplex transaction controller feeding a bidirectional pad stage
// (O_BUFT I/OE out, I_BUF O in). Enforces drive/sample windows and a
// turnaround gap after every transaction so the pad never fights the far end.
// Optional macro BIDIR_PAD_CTRL_CONTENTION_EN adds a sticky err output that
// flags a loopback mismatch on the last drive cycle of each write.
module bidir_pad_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WR_HOLD    = 2,
  parameter int unsigned RD_WAIT    = 3,
  parameter int unsigned TURNAROUND = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bidir_pad_ctrl_if.slave       bus,
  output logic [DATA_WIDTH-1:0] pad_o,
  output logic                  pad_oe,
  input  logic [DATA_WIDTH-1:0] pad_i
`ifdef BIDIR_PAD_CTRL_CONTENTION_EN
  ,
  output logic                  err
`endif
);

  localparam int unsigned MAX_AB  = (WR_HOLD > RD_WAIT) ? WR_HOLD : RD_WAIT;
  localparam int unsigned MAX_CNT = (MAX_AB > TURNAROUND) ? MAX_AB : TURNAROUND;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_TA    = 2'd3
  } state_t;

  state_t                state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic                  wr_q,        wr_d;
  logic [DATA_WIDTH-1:0] rd_q,        rd_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [DATA_WIDTH-1:0] pad_o_q,     pad_o_d;
  logic                  pad_oe_q,    pad_oe_d;

  logic accept_c;
  logic last_c;

  assign accept_c = bus.req_valid && req_ready_q;
  assign last_c   = (cnt_q == '0);

  // State register and all registered outputs; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      rd_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      pad_o_q     <= '0;
      pad_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      pad_o_q     <= pad_o_d;
      pad_oe_q    <= pad_oe_d;
    end
  end

  // Next-state, counter and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    pad_o_d     = pad_o_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          wr_d = bus.req_write;
          if (bus.req_write) begin
            state_d = ST_DRIVE;
            cnt_d   = CNT_W'(WR_HOLD - 1);
            pad_o_d = bus.req_wdata;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      ST_DRIVE: begin
        if (last_c) begin
          state_d = ST_TA;
          cnt_d   = CNT_W'(TURNAROUND - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        // Sample point is the final edge of the wait window.
        if (last_c) begin
          rd_d    = pad_i;
          state_d = ST_TA;
          cnt_d   = CNT_W'(TURNAROUND - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_TA: begin
        if (last_c) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wr_q ? '0 : rd_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Ready and output-enable are registered views of the next state.
    req_ready_d = (state_d == ST_IDLE);
    pad_oe_d    = (state_d == ST_DRIVE);
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign pad_o         = pad_o_q;
  assign pad_oe        = pad_oe_q;

`ifdef BIDIR_PAD_CTRL_CONTENTION_EN
  logic err_q;
  logic err_d;

  // Loopback compare on the last drive cycle; sticky until reset.
  always_comb begin
    err_d = err_q;
    if ((state_q == ST_DRIVE) && last_c && (pad_i != pad_o_q)) begin
      err_d = 1'b1;
    end
  end

  // Contention flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: doc/bidir_pad_ctrl.md
Name: bidir_pad_ctrl

Overview:
- Half-duplex transaction controller that sits directly upstream of the bidirectional pad stage.
- Accepts single-beat write/read requests on a valid/ready interface.
- Drives the pad's output data and output-enable (feeding O_BUFT I/OE) and captures the pad's input-buffer output (from I_BUF O).
- Inserts guaranteed bus-turnaround gaps so the pad is never driven while the far end may still be driving.

Parameters:
- DATA_WIDTH, 8, width of pad data bus and request/response data
- WR_HOLD, 2, cycles PAD_OE is asserted per write (>=1)
- RD_WAIT, 3, cycles from read accept to PAD_I sample point (>=1)
- TURNAROUND, 2, cycles PAD_OE forced low after every transaction (>=1)

Ports:
- CLK  input  1  single clock, all state on rising edge
- RST_N  input  1  asynchronous active-low reset
- REQ_VALID  input  1  request present
- REQ_READY  output  1  controller can accept request
- REQ_WRITE  input  1  1=write, 0=read
- REQ_WDATA  input  DATA_WIDTH  write data
- RSP_VALID  output  1  one-cycle completion pulse
- RSP_RDATA  output  DATA_WIDTH  read data; 0 after a write
- PAD_O  output  DATA_WIDTH  to O_BUFT I
- PAD_OE  output  1  to O_BUFT OE, registered
- PAD_I  input  DATA_WIDTH  from I_BUF O

Behaviour:
- Reset (RST_N low, async):
  - State=IDLE; REQ_READY=1, RSP_VALID=0, RSP_RDATA=0, PAD_O=0, PAD_OE=0; counter cleared.
  - Effect is immediate, including mid-transaction. An in-flight request is dropped with no RSP_VALID.
- States: IDLE, DRIVE, WAIT, TA. Single down-counter, width $clog2(max(WR_HOLD,RD_WAIT,TURNAROUND)+1).
- IDLE:
  - REQ_READY=1, PAD_OE=0.
  - Accept when REQ_VALID&&REQ_READY at edge k. Latch REQ_WRITE/REQ_WDATA.
  - Write -> DRIVE (cnt=WR_HOLD-1). Read -> WAIT (cnt=RD_WAIT-1).
- DRIVE:
  - PAD_OE=1, PAD_O=latched data in cycles k+1..k+WR_HOLD. Then -> TA.
- WAIT:
  - PAD_OE=0 for cycles k+1..k+RD_WAIT.
  - PAD_I is registered into the read-data register at the final edge of WAIT, i.e. the end of cycle k+RD_WAIT. Then -> TA.
- TA:
  - PAD_OE=0 for TURNAROUND cycles. Then -> IDLE.
- RSP_VALID:
  - High for exactly the first IDLE cycle after TA; REQ_READY is also 1 in that cycle.
  - RSP_RDATA updates on that same edge (captured data for reads, 0 for writes) and holds until the next completion.
- REQ_READY is 0 in DRIVE/WAIT/TA. Requests presented then are not accepted and must be held by the requester.
- Occupancy between accepts:
  - write: WR_HOLD+TURNAROUND+1 cycles
  - read: RD_WAIT+TURNAROUND+1 cycles
- Back-to-back: a new request may be accepted in the RSP_VALID cycle.
- PAD_OE invariants:
  - Never high in two non-consecutive write windows without at least TURNAROUND low cycles between them.
  - Never high in any read transaction.
- PAD_O holds its last value when PAD_OE=0; content is don't-care for the pad.

Optional Feature:
- Macro BIDIR_PAD_CTRL_CONTENTION_EN.
- Defined:
  - Adds output ERR (1 bit, reset 0).
  - On the last DRIVE cycle, PAD_I (loopback through I_BUF) is compared with PAD_O. Any mismatch sets ERR sticky until RST_N.
  - Timing and all other outputs are unchanged.
- Undefined: no ERR port, no compare logic.

Test Plan:
- Reset then idle:
  - RST_N low 3 cycles, release -> PAD_OE=0, REQ_READY=1, RSP_VALID=0, RSP_RDATA=0.
- Write 0xA5 accepted at edge k (defaults):
  - PAD_OE=1, PAD_O=0xA5 in cycles k+1,k+2.
  - PAD_OE=0 in k+3,k+4.
  - RSP_VALID=1 with RSP_RDATA=0 in k+5; REQ_READY=0 in k+1..k+4.
- Read accepted at k, PAD_I=0x3C in cycle k+3 (0xFF otherwise):
  - PAD_OE=0 throughout.
  - RSP_VALID=1 with RSP_RDATA=0x3C in cycle k+6.
- Write 0x11 then read held on REQ_VALID:
  - Read accepted in write's RSP_VALID cycle.
  - PAD_OE low for >=2 cycles before any read sampling; no overlap of drive and sample.
- Reset mid-write:
  - RST_N low during cycle k+1 -> PAD_OE falls asynchronously.
  - After release: IDLE, no RSP_VALID for the aborted write.
- With BIDIR_PAD_CTRL_CONTENTION_EN:
  - Write 0x0F with PAD_I forced 0x0E -> ERR=1 from cycle k+3, stays 1 through a later clean write, clears only on RST_N.
